// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Registered execute stage for the SHA datapath ALU. It accepts one operation
//   per cycle over a valid/ready handshake. It computes the result and the
//   {N,Z,C,V} flags at acceptance. Results go to writeback through a 2-entry
//   buffer (output register plus skid register), so back-pressure never drops
//   or duplicates an operation.
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset
//   i_in_valid   upstream presents an operation
//   o_in_ready   stage can accept (registered, independent of i_out_ready)
//   i_op         opcode: 0 AND, 1 OR, 2 XOR, 3 NOT a, 4 ADD, 5 SUB, 6 SHR,
//                7 SHL, 8 ROTR, 9 ROTL, 10-15 illegal
//   i_a, i_b     operands; i_b[SHW-1:0] is the shift/rotate amount
//   o_out_valid  result available to writeback
//   i_out_ready  writeback accepts
//   o_result     operation result
//   o_flags      {N,Z,C,V}
//   o_illegal    presented result came from an illegal opcode
//   o_op_count   results transferred out since reset (wraps)
//
// Buffer FSM
//   state   | meaning
//   S_EMPTY | output register empty, nothing presented to writeback
//   S_ONE   | output register holds the oldest result, skid register empty
//   S_TWO   | output and skid registers both full, upstream stalled
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH),
  parameter int CNTW  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags,
  output logic             o_illegal,
  output logic [CNTW-1:0]  o_op_count
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_ROTR = 4'd8;
  localparam logic [3:0] OP_ROTL = 4'd9;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;

  logic [WIDTH-1:0] r_out_result;
  logic [3:0]       r_out_flags;
  logic             r_out_illegal;
  logic [WIDTH-1:0] r_skid_result;
  logic [3:0]       r_skid_flags;
  logic             r_skid_illegal;
  logic             r_in_ready;
  logic [CNTW-1:0]  r_op_count;

  logic             w_acc;
  logic             w_drn;
  logic             w_load_out_new;
  logic             w_load_out_skid;
  logic             w_load_skid;

  // ---------------------------------------------------------------------------
  // Operator units
  // ---------------------------------------------------------------------------
  logic [SHW-1:0]   w_sh;
  logic [SHW:0]     w_sh_inv;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH:0]   w_shr_ext;
  logic [WIDTH:0]   w_shl_ext;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_ill;
  logic [3:0]       w_flags;

  assign w_sh     = i_b[SHW-1:0];
  // Complementary amount for rotates. With sh=0 it equals WIDTH, so the
  // wrapped-around half shifts out completely and a passes unchanged.
  assign w_sh_inv = (SHW+1)'(WIDTH) - {1'b0, w_sh};

  // The top bit of the extended difference is the unsigned borrow (a<b).
  assign w_add = {1'b0, i_a} + {1'b0, i_b};
  assign w_sub = {1'b0, i_a} - {1'b0, i_b};

  // Shifting a one-bit-extended copy parks the last bit shifted out at a fixed
  // position: bit 0 for SHR, bit WIDTH for SHL. Both read 0 when sh=0.
  assign w_shr_ext = {i_a, 1'b0} >> w_sh;
  assign w_shl_ext = {1'b0, i_a} << w_sh;

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (i_op)
      OP_AND:  w_res = i_a & i_b;
      OP_OR:   w_res = i_a | i_b;
      OP_XOR:  w_res = i_a ^ i_b;
      OP_NOT:  w_res = ~i_a;
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_add[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_sub[WIDTH-1] != i_a[WIDTH-1]);
      end
      OP_SHR: begin
        w_res = w_shr_ext[WIDTH:1];
        w_c   = w_shr_ext[0];
      end
      OP_SHL: begin
        w_res = w_shl_ext[WIDTH-1:0];
        w_c   = w_shl_ext[WIDTH];
      end
      OP_ROTR: w_res = (i_a >> w_sh) | (i_a << w_sh_inv);
      OP_ROTL: w_res = (i_a << w_sh) | (i_a >> w_sh_inv);
      default: w_ill = 1'b1;
    endcase
    // An illegal op leaves w_res at zero, which yields flags {0,1,0,0}.
    w_flags = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
  end

  // ---------------------------------------------------------------------------
  // Handshake and buffer FSM
  // ---------------------------------------------------------------------------
  assign o_out_valid = (r_state != S_EMPTY);
  assign o_in_ready  = r_in_ready;
  // r_in_ready is low in S_TWO, so no transfer in is possible from that state.
  assign w_acc       = i_in_valid && r_in_ready;
  assign w_drn       = o_out_valid && i_out_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_load_out_new  = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_acc) begin
          w_state_nx     = S_ONE;
          w_load_out_new = 1'b1;
        end
      end
      S_ONE: begin
        if (w_acc && w_drn) begin
          w_load_out_new = 1'b1;
        end else if (w_acc) begin
          w_state_nx  = S_TWO;
          w_load_skid = 1'b1;
        end else if (w_drn) begin
          w_state_nx = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_drn) begin
          w_state_nx      = S_ONE;
          w_load_out_skid = 1'b1;
        end
      end
      default: w_state_nx = S_EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register, skid register, ready and counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_result   <= '0;
      r_out_flags    <= '0;
      r_out_illegal  <= 1'b0;
      r_skid_result  <= '0;
      r_skid_flags   <= '0;
      r_skid_illegal <= 1'b0;
      r_in_ready     <= 1'b1;
      r_op_count     <= '0;
    end else begin
      if (w_load_out_new) begin
        r_out_result  <= w_res;
        r_out_flags   <= w_flags;
        r_out_illegal <= w_ill;
      end else if (w_load_out_skid) begin
        r_out_result  <= r_skid_result;
        r_out_flags   <= r_skid_flags;
        r_out_illegal <= r_skid_illegal;
      end

      if (w_load_skid) begin
        r_skid_result  <= w_res;
        r_skid_flags   <= w_flags;
        r_skid_illegal <= w_ill;
      end else if (w_load_out_skid) begin
        r_skid_result  <= '0;
        r_skid_flags   <= '0;
        r_skid_illegal <= 1'b0;
      end

      // Registered ready: computed from the next state, so it never depends
      // combinationally on i_out_ready.
      r_in_ready <= (w_state_nx != S_TWO);

      if (w_drn) begin
        r_op_count <= r_op_count + 1'b1;
      end
    end
  end

  assign o_result   = r_out_result;
  assign o_flags    = r_out_flags;
  assign o_illegal  = r_out_illegal;
  assign o_op_count = r_op_count;

endmodule
